// File: rtl/game_tick_gen.sv
// ---------------------------------------------------------------------------
// game_tick_gen
//
// Turns a free-running 32-bit divider count into single-cycle move enables
// for the snake logic. A speed level picks one divider bit (the tap). Each
// armed rising edge of that tap becomes one move_tick, issued one clk after
// the clkdiv sample on which the tap rose. A start/pause/stop state machine
// gates the ticks. While paused, step issues one tick on demand. Issued ticks
// are counted.
//
// Parameters
//   BASE_TAP   divider bit used at speed 0 (7..31). Tap = BASE_TAP - speed.
//   CNT_W      width of the tick counter.
//
// Ports
//   clk        system clock (same clock as the divider)
//   rst        asynchronous, active-high reset
//   clkdiv     free-running divider count, synchronous to clk
//   speed      speed level 0..7
//   start      pulse: begin or restart ticking (clears tick_cnt)
//   pause_tgl  pulse: toggle RUN <-> PAUSE
//   step       pulse: one tick while in PAUSE
//   stop       pulse: return to IDLE (tick_cnt is kept)
//   move_tick  one-cycle move enable (registered)
//   running    high in RUN (registered)
//   paused     high in PAUSE (registered)
//   tick_cnt   ticks issued since the last start (wraps silently)
// ---------------------------------------------------------------------------

// Protocol properties of the tick generator outputs.
module game_tick_gen_chk (
    input logic clk,
    input logic rst,
    input logic move_tick,
    input logic running,
    input logic paused
);

    a_tick_single_cycle : assert property (@(posedge clk) disable iff (rst)
        move_tick |=> !move_tick);

    a_state_onehot : assert property (@(posedge clk) disable iff (rst)
        !(running && paused));

endmodule

module game_tick_gen #(
    parameter int BASE_TAP = 22,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      clkdiv,
    input  logic [2:0]       speed,
    input  logic             start,
    input  logic             pause_tgl,
    input  logic             step,
    input  logic             stop,
    output logic             move_tick,
    output logic             running,
    output logic             paused,
    output logic [CNT_W-1:0] tick_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    localparam logic [4:0]       BASE_TAP_W = 5'(BASE_TAP);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             move_tick_q, move_tick_d;
    logic             running_q, running_d;
    logic             paused_q, paused_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             tap_prev_q;
    logic             armed_q, armed_d;
    logic [2:0]       speed_q;

    logic [4:0]       speed_ext_s;
    logic [4:0]       tap_idx_s;
    logic             tap_s;
    logic             speed_chg_s;
    logic             rise_s;
    logic             tick_s;
    logic             clr_cnt_s;
    logic             enter_run_s;

    assign speed_ext_s = {2'b00, speed};

    // Tap index selection; a speed above BASE_TAP saturates at bit 0.
    always_comb begin
        tap_idx_s = 5'd0;
        if (speed_ext_s > BASE_TAP_W) begin
            tap_idx_s = 5'd0;
        end else begin
            tap_idx_s = BASE_TAP_W - speed_ext_s;
        end
    end

    assign tap_s       = clkdiv[tap_idx_s];
    assign speed_chg_s = (speed != speed_q);
    // tap_prev_q belongs to the old tap during a speed change, so the edge
    // is suppressed in that cycle as well as disarmed for later.
    assign rise_s      = tap_s & ~tap_prev_q & armed_q & ~speed_chg_s;

    // Next-state decode; stop > start > pause_tgl > step/rise.
    always_comb begin
        state_d     = state_q;
        tick_s      = 1'b0;
        clr_cnt_s   = 1'b0;
        enter_run_s = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d     = ST_RUN;
            clr_cnt_s   = 1'b1;
            enter_run_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (pause_tgl) begin
                        state_d = ST_PAUSE;
                    end else if (rise_s) begin
                        tick_s = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (pause_tgl) begin
                        state_d     = ST_RUN;
                        enter_run_s = 1'b1;
                    end else if (step) begin
                        tick_s = 1'b1;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Counter, arming and registered output decodes.
    always_comb begin
        tick_cnt_d  = tick_cnt_q;
        armed_d     = armed_q;
        move_tick_d = tick_s;
        running_d   = (state_d == ST_RUN);
        paused_d    = (state_d == ST_PAUSE);

        if (clr_cnt_s) begin
            tick_cnt_d = CNT_ZERO;
        end else if (tick_s) begin
            tick_cnt_d = tick_cnt_q + CNT_ONE;
        end else begin
            tick_cnt_d = tick_cnt_q;
        end

        // Clearing wins over setting so the next tick always needs a fresh
        // low-then-high tap sequence.
        if (speed_chg_s || enter_run_s || tick_s) begin
            armed_d = 1'b0;
        end else if (!tap_s) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            move_tick_q <= 1'b0;
            running_q   <= 1'b0;
            paused_q    <= 1'b0;
            tick_cnt_q  <= CNT_ZERO;
            tap_prev_q  <= 1'b0;
            armed_q     <= 1'b0;
            speed_q     <= 3'd0;
        end else begin
            state_q     <= state_d;
            move_tick_q <= move_tick_d;
            running_q   <= running_d;
            paused_q    <= paused_d;
            tick_cnt_q  <= tick_cnt_d;
            tap_prev_q  <= tap_s;
            armed_q     <= armed_d;
            speed_q     <= speed;
        end
    end

    assign move_tick = move_tick_q;
    assign running   = running_q;
    assign paused    = paused_q;
    assign tick_cnt  = tick_cnt_q;

    game_tick_gen_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .move_tick (move_tick_q),
        .running   (running_q),
        .paused    (paused_q)
    );

endmodule

// File: tb/tb_game_tick_gen.sv
module tb_game_tick_gen;

    logic        clk;
    logic        rst;
    logic [31:0] clkdiv;
    logic [2:0]  speed;
    logic        start, pause_tgl, step, stop;
    logic        move_tick, running, paused;
    logic [3:0]  tick_cnt;

    int          n_chk;
    int          n_fail;
    bit          freeze;
    logic [31:0] sampled;
    logic [31:0] last_s;

    game_tick_gen #(.BASE_TAP(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clkdiv    (clkdiv),
        .speed     (speed),
        .start     (start),
        .pause_tgl (pause_tgl),
        .step      (step),
        .stop      (stop),
        .move_tick (move_tick),
        .running   (running),
        .paused    (paused),
        .tick_cnt  (tick_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

    typedef struct {
        logic       st;
        logic       pt;
        logic       sp;
        logic       so;
        logic       em;
        logic       er;
        logic       ep;
        logic [3:0] ec;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clk: records the clkdiv value seen by the edge, returns 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        sampled = clkdiv;
        #1;
        if (!freeze) clkdiv = clkdiv + 32'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    // Runs until n ticks are seen or budget expires; every tick must land on phase.
    task automatic run_ticks(input string nm, input int n, input int budget,
                             input logic [31:0] mask, input logic [31:0] phase,
                             output logic [31:0] first_s);
        int got;
        got = 0;
        first_s = 32'hFFFF_FFFF;
        for (int c = 0; c < budget && got < n; c++) begin
            tick();
            if (move_tick) begin
                if (got == 0) first_s = sampled;
                got++;
                last_s = sampled;
                chk({nm, "_phase"}, sampled & mask, phase);
            end
        end
        chk({nm, "_count"}, got, n);
    endtask

    task automatic quiet(input string nm, input int n);
        int got;
        got = 0;
        for (int c = 0; c < n; c++) begin
            tick();
            if (move_tick) got++;
        end
        chk(nm, got, 0);
    endtask

    initial begin
        logic [31:0] fs;
        logic [31:0] s0;
        logic [3:0]  cnt0;

        n_chk = 0; n_fail = 0;
        rst = 1'b0; clkdiv = 32'd0; speed = 3'd0; freeze = 1'b1;
        start = 1'b0; pause_tgl = 1'b0; step = 1'b0; stop = 1'b0;
        last_s = 32'd0;

        // st pt sp so | move run pause cnt   (clkdiv held at 0: no tap edges)
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};

        // Reset values, observed while reset is held.
        #1 rst = 1'b1;
        #2;
        chk("rst_move", move_tick, 0);
        chk("rst_running", running, 0);
        chk("rst_paused", paused, 0);
        chk("rst_cnt", tick_cnt, 0);
        do_reset();

        // Control table: request priority and state transitions.
        for (int i = 0; i < 18; i++) begin
            start = vecs[i].st; pause_tgl = vecs[i].pt; step = vecs[i].sp; stop = vecs[i].so;
            tick();
            start = 1'b0; pause_tgl = 1'b0; step = 1'b0; stop = 1'b0;
            chk($sformatf("vec%0d_move", i), move_tick, vecs[i].em);
            chk($sformatf("vec%0d_running", i), running, vecs[i].er);
            chk($sformatf("vec%0d_paused", i), paused, vecs[i].ep);
            chk($sformatf("vec%0d_cnt", i), tick_cnt, vecs[i].ec);
        end

        // Speed 0 from a counting divider: start at cycle 10, ticks on bit-4 rises.
        clkdiv = 32'd0; freeze = 1'b0; speed = 3'd0;
        do_reset();
        repeat (9) tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("a_running", running, 1);
        run_ticks("a_ticks", 5, 200, 32'd31, 32'd16, fs);
        chk("a_first", fs, 32'd16);
        chk("a_cnt", tick_cnt, 5);
        chk("a_running2", running, 1);

        // Speed 0 -> 2 right after a tick: first tick on the next bit-2 rise, then every 8.
        s0 = last_s;
        speed = 3'd2;
        run_ticks("b_ticks", 4, 60, 32'd7, 32'd4, fs);
        chk("b_first_delay", fs - s0, 32'd4);

        // Speed 2 -> 0 on a sample where the new tap is high and the old tap was low.
        while (clkdiv[4:0] != 5'd17) tick();
        s0 = clkdiv;
        speed = 3'd0;
        run_ticks("b2_ticks", 1, 64, 32'd31, 32'd16, fs);
        chk("b2_first_delay", fs - s0, 32'd31);

        // Pause: no ticks, three steps, resume with no immediate tick.
        pause_tgl = 1'b1; tick(); pause_tgl = 1'b0;
        chk("c_paused", paused, 1);
        chk("c_running", running, 0);
        quiet("c_quiet", 100);
        cnt0 = tick_cnt;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; tick(); step = 1'b0;
            chk($sformatf("c_step%0d_move", i), move_tick, 1);
            tick();
            chk($sformatf("c_step%0d_gap", i), move_tick, 0);
        end
        cnt0 = cnt0 + 4'd3;
        chk("c_cnt", tick_cnt, cnt0);
        while (clkdiv[4:0] != 5'd16) tick();
        s0 = clkdiv;
        pause_tgl = 1'b1; tick(); pause_tgl = 1'b0;
        chk("c_resume_running", running, 1);
        chk("c_resume_move", move_tick, 0);
        run_ticks("c_after", 1, 64, 32'd31, 32'd16, fs);
        chk("c_after_delay", fs - s0, 32'd32);

        // stop + start together: stop wins, count kept; later start clears it.
        cnt0 = tick_cnt;
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chk("d_running", running, 0);
        chk("d_paused", paused, 0);
        chk("d_cnt_kept", tick_cnt, cnt0);
        quiet("d_quiet", 40);
        chk("d_cnt_kept2", tick_cnt, cnt0);
        start = 1'b1; tick(); start = 1'b0;
        chk("d_restart_cnt", tick_cnt, 0);
        chk("d_restart_running", running, 1);
        run_ticks("d_ticks", 1, 64, 32'd31, 32'd16, fs);
        chk("d_cnt1", tick_cnt, 1);

        // Counter wrap with a 4-bit counter: 17 steps give 1..15, 0, 1.
        start = 1'b1; tick(); start = 1'b0;
        pause_tgl = 1'b1; tick(); pause_tgl = 1'b0;
        cnt0 = 4'd0;
        for (int i = 0; i < 17; i++) begin
            step = 1'b1; tick(); step = 1'b0;
            cnt0 = cnt0 + 4'd1;
            chk($sformatf("e_move%0d", i), move_tick, 1);
            chk($sformatf("e_cnt%0d", i), tick_cnt, cnt0);
            tick();
        end

        // Asynchronous reset while move_tick is high.
        step = 1'b1; tick(); step = 1'b0;
        chk("f_move_before", move_tick, 1);
        #2 rst = 1'b1;
        #1;
        chk("f_move", move_tick, 0);
        chk("f_running", running, 0);
        chk("f_paused", paused, 0);
        chk("f_cnt", tick_cnt, 0);
        #2 rst = 1'b0;
        quiet("f_quiet", 80);
        chk("f_idle", running, 0);
        start = 1'b1; tick(); start = 1'b0;
        run_ticks("f_ticks", 1, 64, 32'd31, 32'd16, fs);
        chk("f_cnt1", tick_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/game_tick_gen.md
Name: game_tick_gen

Overview:
- Consumer of the free-running 32-bit divider bus. Selects one divider bit (tap) according to a speed level.
- Converts each rising edge of that tap into a single-cycle move enable for the snake logic in the clk domain.
- Gates ticks with a start/pause/stop state machine, supports single-step while paused, and counts issued ticks.

Parameters:
- BASE_TAP, 22, divider bit used at speed 0. Legal range 7..31.
- CNT_W, 16, width of the tick counter.

Ports:
- clk  input  1  system clock, same clock that drives the divider.
- rst  input  1  asynchronous, active-high reset.
- clkdiv  input  32  free-running divider count, synchronous to clk.
- speed  input  3  speed level 0..7. Tap index = BASE_TAP - speed.
- start  input  1  one-cycle request: begin or restart game ticking.
- pause_tgl  input  1  one-cycle request: toggle between RUN and PAUSE.
- step  input  1  one-cycle request: issue one tick while in PAUSE.
- stop  input  1  one-cycle request: game over, return to IDLE.
- move_tick  output  1  one-cycle move enable.
- running  output  1  high in RUN.
- paused  output  1  high in PAUSE.
- tick_cnt  output  CNT_W  number of ticks issued since the last start.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; move_tick=0; running=0; paused=0; tick_cnt=0; tap_prev=0; armed=0; speed_q=0.
- Tap selection: tap = clkdiv[BASE_TAP - speed], combinational from the current inputs. tap_prev and speed_q are registered every cycle.
- Edge detection: rise = tap & ~tap_prev & armed.
- Arming:
  - armed is set in any cycle where tap==0.
  - armed is cleared when speed != speed_q, when entering RUN (from IDLE or PAUSE), and in the same cycle a tick is issued.
  - Effect: a speed change or a resume never produces a spurious immediate tick. The first tick afterwards needs tap to go low and then high again.
- States:
  - IDLE: no ticks. start -> RUN; on that transition tick_cnt is cleared to 0.
  - RUN: rise -> move_tick=1 in the next cycle (registered output; latency 1 clk from the clkdiv sample where the tap rises). pause_tgl -> PAUSE. start -> RUN with tick_cnt cleared.
  - PAUSE: rise is ignored. step -> move_tick=1 in the next cycle, state stays PAUSE. pause_tgl -> RUN.
- stop: from any state -> IDLE next cycle, with no tick in that cycle. tick_cnt holds its value so the score/debug display survives.
- Priority when requests coincide: stop > start > pause_tgl > step.
  - A rise or step in the same cycle as a state-changing request is dropped.
  - step is ignored outside PAUSE. pause_tgl is ignored in IDLE.
- move_tick: exactly one cycle wide. It never asserts on two consecutive cycles, guaranteed by armed clearing and by step being a pulse.
- tick_cnt: increments in the cycle move_tick is asserted. Wraps from 2^CNT_W-1 to 0 with no flag.
- running/paused: registered decodes of state, valid the cycle after the transition.
- Divider wrap-around (0xFFFFFFFF -> 0): the tap goes low, which is a normal re-arm. No special handling.
- Reset asserted mid-RUN: all outputs go to reset values immediately (asynchronous), including a move_tick that was high.

Test Plan:
- BASE_TAP=4, speed=0, start at cycle 10, drive clkdiv from a counter -> move_tick every 32 cycles, one cycle after each bit-4 rise. After 5 periods, tick_cnt=5 and running=1.
- In RUN at speed 0, change speed to 2 just after a tick -> no tick until bit 2 has been low and then risen. After that, period is 8 cycles.
- pause_tgl in RUN -> paused=1 and no ticks for 100 cycles. Three step pulses -> exactly 3 ticks, tick_cnt +3. pause_tgl -> resume with no immediate tick.
- stop and start asserted in the same cycle while in RUN -> IDLE, tick_cnt unchanged. A later start alone -> tick_cnt=0, then ticks resume.
- CNT_W=4, run 17 ticks -> tick_cnt goes 15 -> 0 -> 1.
- Assert rst asynchronously during a move_tick cycle -> move_tick/running/tick_cnt go to 0 before the next clk edge. No ticks until start.
